// File: rtl/store_pkg.sv
// Shared definitions for the store alignment queue.
//   SIZE_*        : in_size encodings (byte, half, word, dword)
//   beat_state_e  : output beat FSM state encoding
//   size_bytes()  : size encoding -> number of bytes written (1/2/4/8)
package store_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } beat_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 4'd1;
            SIZE_H:  return 4'd2;
            SIZE_W:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// Combinational lane placement for one queued store.
// Places right-justified store data onto byte lanes across a two-beat window
// and produces the matching byte strobes.
//   addr, data, size  : raw queued store
//   lo_addr, hi_addr  : bus-aligned addresses of beat 0 and beat 1
//   lo_data, hi_data  : lane-positioned data for beat 0 / beat 1
//   lo_strb, hi_strb  : byte enables for beat 0 / beat 1 (hi_strb == 0 -> single beat)
module store_lane_shift
    import store_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   data,
    input  logic [1:0]          size,
    output logic [31:0]         lo_addr,
    output logic [31:0]         hi_addr,
    output logic [DATA_W-1:0]   lo_data,
    output logic [DATA_W-1:0]   hi_data,
    output logic [DATA_W/8-1:0] lo_strb,
    output logic [DATA_W/8-1:0] hi_strb
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    logic [OFF_W-1:0]    off;
    logic [2*DATA_W-1:0] lanes;
    logic [2*BYTES-1:0]  mask;

    assign off   = addr[OFF_W-1:0];
    assign lanes = {{DATA_W{1'b0}}, data} << {off, 3'b000};
    // Contiguous size_bytes-wide run of ones, slid up to the starting lane.
    assign mask  = (2*BYTES)'((16'd1 << size_bytes(size)) - 16'd1) << off;

    assign lo_addr = {addr[31:OFF_W], {OFF_W{1'b0}}};
    assign hi_addr = lo_addr + 32'(BYTES);
    assign lo_data = lanes[DATA_W-1:0];
    assign hi_data = lanes[2*DATA_W-1:DATA_W];
    assign lo_strb = mask[BYTES-1:0];
    assign hi_strb = mask[2*BYTES-1:BYTES];

endmodule

// File: rtl/store_align_queue.sv
// Store alignment queue: buffers MEM-stage stores and issues them as
// bus-aligned write beats with byte strobes, splitting lane-crossing stores
// into two beats when MISALIGN_SPLIT=1 or rejecting them otherwise.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : request handshake; in_addr/in_data/in_size payload
//   out_valid/out_ready  : bus beat handshake; out_addr/out_data/out_strb payload
//   store_err, err_addr  : one-cycle pulse and address of the last rejected store
//   count                : occupied queue entries
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | queue empty (or just reset), no beat driven
// ST_BEAT0 | driving the low (or only) beat of the head entry
// ST_BEAT1 | driving the high beat of a split head entry
module store_align_queue
    import store_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4,
    parameter int MISALIGN_SPLIT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [1:0]             in_size,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [DATA_W/8-1:0]    out_strb,
    output logic                   store_err,
    output logic [31:0]            err_addr,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [31:0]       addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [1:0]        size_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    beat_state_e      state_q, state_d;
    logic             err_q, err_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic       accept, reject, push, pop, more_after_pop;
    logic       size_illegal, misaligned;
    logic [3:0] req_bytes;

    logic [31:0]         lo_addr, hi_addr;
    logic [DATA_W-1:0]   lo_data, hi_data;
    logic [DATA_W/8-1:0] lo_strb, hi_strb;

    // Readiness depends only on occupancy, so a pop never opens room in the same cycle.
    assign in_ready = (count_q < FULL_CNT);
    assign accept   = in_valid & in_ready;

    assign req_bytes    = size_bytes(in_size);
    assign size_illegal = (DATA_W == 32) && (in_size == SIZE_D);
    assign misaligned   = (in_addr[3:0] & (req_bytes - 4'd1)) != 4'd0;
    assign reject       = size_illegal || (misaligned && (MISALIGN_SPLIT == 0));
    assign push         = accept & ~reject;

    store_lane_shift #(
        .DATA_W (DATA_W)
    ) u_lane_shift (
        .addr    (addr_mem[rd_ptr_q]),
        .data    (data_mem[rd_ptr_q]),
        .size    (size_mem[rd_ptr_q]),
        .lo_addr (lo_addr),
        .hi_addr (hi_addr),
        .lo_data (lo_data),
        .hi_data (hi_data),
        .lo_strb (lo_strb),
        .hi_strb (hi_strb)
    );

    // A same-cycle push keeps the queue non-empty even when the head leaves.
    assign more_after_pop = (count_q > ONE_CNT) || push;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        out_strb  = '0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_BEAT0;
            end
            ST_BEAT0: begin
                out_valid = 1'b1;
                out_addr  = lo_addr;
                out_data  = lo_data;
                out_strb  = lo_strb;
                if (out_ready) begin
                    if (hi_strb != '0) begin
                        state_d = ST_BEAT1;
                    end else begin
                        pop     = 1'b1;
                        state_d = more_after_pop ? ST_BEAT0 : ST_IDLE;
                    end
                end
            end
            ST_BEAT1: begin
                out_valid = 1'b1;
                out_addr  = hi_addr;
                out_data  = hi_data;
                out_strb  = hi_strb;
                if (out_ready) begin
                    pop     = 1'b1;
                    state_d = more_after_pop ? ST_BEAT0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
        err_d      = accept & reject;
        err_addr_d = (accept & reject) ? in_addr : err_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= in_addr;
            data_mem[wr_ptr_q] <= in_data;
            size_mem[wr_ptr_q] <= in_size;
        end
    end

    assign count     = count_q;
    assign store_err = err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_store_align_queue.sv
module tb_store_align_queue;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    beat_t exp_a[$];

    // a: 32-bit, split enabled
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_store_err;
    logic [31:0] a_in_addr, a_in_data, a_out_addr, a_out_data, a_err_addr;
    logic [1:0] a_in_size;
    logic [3:0] a_out_strb;
    logic [2:0] a_count;
    // n: 32-bit, split disabled
    logic n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_store_err;
    logic [31:0] n_in_addr, n_in_data, n_out_addr, n_out_data, n_err_addr;
    logic [1:0] n_in_size;
    logic [3:0] n_out_strb;
    logic [2:0] n_count;
    // w: 64-bit, split disabled
    logic w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_store_err;
    logic [31:0] w_in_addr, w_out_addr, w_err_addr;
    logic [63:0] w_in_data, w_out_data;
    logic [1:0] w_in_size;
    logic [7:0] w_out_strb;
    logic [2:0] w_count;

    store_align_queue #(.DATA_W(32), .DEPTH(4), .MISALIGN_SPLIT(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_addr(a_in_addr), .in_data(a_in_data), .in_size(a_in_size),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr),
        .out_data(a_out_data), .out_strb(a_out_strb), .store_err(a_store_err),
        .err_addr(a_err_addr), .count(a_count));

    store_align_queue #(.DATA_W(32), .DEPTH(4), .MISALIGN_SPLIT(0)) dut_n (
        .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_addr(n_in_addr), .in_data(n_in_data), .in_size(n_in_size),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_addr(n_out_addr),
        .out_data(n_out_data), .out_strb(n_out_strb), .store_err(n_store_err),
        .err_addr(n_err_addr), .count(n_count));

    store_align_queue #(.DATA_W(64), .DEPTH(4), .MISALIGN_SPLIT(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_addr(w_in_addr), .in_data(w_in_data), .in_size(w_in_size),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_addr(w_out_addr),
        .out_data(w_out_data), .out_strb(w_out_strb), .store_err(w_store_err),
        .err_addr(w_err_addr), .count(w_count));

    // Byte-by-byte reference for the 32-bit queue: each written byte goes to
    // lane (addr+i)%4 of whichever aligned word it lands in.
    function automatic void model_push_a(input logic [31:0] addr, input logic [31:0] data,
                                         input logic [1:0] sz);
        beat_t b0, b1;
        logic [31:0] base;
        logic [31:0] ba;
        int nb;
        nb   = 1 << sz;
        base = addr & ~32'h3;
        b0.addr = base;          b0.data = '0; b0.strb = '0;
        b1.addr = base + 32'd4;  b1.data = '0; b1.strb = '0;
        for (int i = 0; i < nb; i++) begin
            ba = addr + 32'(i);
            if (ba[31:2] == addr[31:2]) begin
                b0.data[8*ba[1:0] +: 8] = data[8*i +: 8];
                b0.strb[ba[1:0]] = 1'b1;
            end else begin
                b1.data[8*ba[1:0] +: 8] = data[8*i +: 8];
                b1.strb[ba[1:0]] = 1'b1;
            end
        end
        exp_a.push_back(b0);
        if (b1.strb != 8'h0) exp_a.push_back(b1);
    endfunction

    function automatic beat_t mk(input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb);
        beat_t b;
        b.addr = addr; b.data = data; b.strb = strb;
        return b;
    endfunction

    task automatic drive_a(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        a_in_valid = 1'b1; a_in_addr = addr; a_in_data = data; a_in_size = sz;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drive_n(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
        n_in_valid = 1'b1; n_in_addr = addr; n_in_data = data; n_in_size = sz;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] sz);
        w_in_valid = 1'b1; w_in_addr = addr; w_in_data = data; w_in_size = sz;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
    endtask

    task automatic drain_a(input string tag, input int budget);
        beat_t e;
        int cyc = 0;
        a_out_ready = 1'b1;
        while (exp_a.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (a_out_valid) begin
                e = exp_a.pop_front();
                if (a_out_addr !== e.addr || a_out_data !== e.data[31:0] || a_out_strb !== e.strb[3:0]) begin
                    n_err++;
                    $display("FAIL %s beat: got addr=%h data=%h strb=%b, want addr=%h data=%h strb=%b",
                             tag, a_out_addr, a_out_data, a_out_strb, e.addr, e.data[31:0], e.strb[3:0]);
                end
            end else if (a_out_strb !== 4'b0) begin
                n_err++;
                $display("FAIL %s idle_strb: got %b, want 0000", tag, a_out_strb);
            end
        end
        n_cmp++;
        if (exp_a.size() != 0) begin
            n_err++;
            $display("FAIL %s timeout: %0d beats still expected, want 0", tag, exp_a.size());
            exp_a.delete();
        end
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin
            n_err++;
            $display("FAIL %s after_drain: got valid=%b count=%0d, want valid=0 count=0",
                     tag, a_out_valid, a_count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_count !== 3'd0 || a_out_valid !== 1'b0 ||
            a_store_err !== 1'b0 || a_err_addr !== 32'h0 || a_out_strb !== 4'h0) begin
            n_err++;
            $display("FAIL reset_a: got rdy=%b cnt=%0d vld=%b err=%b eaddr=%h strb=%b, want 1 0 0 0 0 0",
                     a_in_ready, a_count, a_out_valid, a_store_err, a_err_addr, a_out_strb);
        end
        n_cmp++;
        if (n_in_ready !== 1'b1 || n_count !== 3'd0 || n_out_valid !== 1'b0 || n_store_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_n: got rdy=%b cnt=%0d vld=%b err=%b, want 1 0 0 0",
                     n_in_ready, n_count, n_out_valid, n_store_err);
        end
        n_cmp++;
        if (w_in_ready !== 1'b1 || w_count !== 3'd0 || w_out_valid !== 1'b0 || w_out_strb !== 8'h0) begin
            n_err++;
            $display("FAIL reset_w: got rdy=%b cnt=%0d vld=%b strb=%h, want 1 0 0 00",
                     w_in_ready, w_count, w_out_valid, w_out_strb);
        end
    endtask

    task automatic test_byte_store();
        exp_a.push_back(mk(32'h10, 64'hAB000000, 8'b1000));
        drive_a(32'h13, 32'hAB, 2'b00);
        drain_a("sb_0x13", 20);
    endtask

    task automatic test_split();
        exp_a.push_back(mk(32'h04, 64'h33440000, 8'b1100));
        exp_a.push_back(mk(32'h08, 64'h00001122, 8'b0011));
        drive_a(32'h06, 32'h11223344, 2'b10);
        n_cmp++;
        if (a_store_err !== 1'b0 || a_count !== 3'd1) begin
            n_err++;
            $display("FAIL split_accept: got err=%b cnt=%0d, want err=0 cnt=1", a_store_err, a_count);
        end
        drain_a("sw_0x06", 20);
    endtask

    task automatic test_misalign_err();
        drive_n(32'h21, 32'hBEEF, 2'b01);
        n_cmp++;
        if (n_store_err !== 1'b1 || n_err_addr !== 32'h21 || n_count !== 3'd0) begin
            n_err++;
            $display("FAIL sh_0x21_err: got err=%b eaddr=%h cnt=%0d, want 1 00000021 0",
                     n_store_err, n_err_addr, n_count);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (n_store_err !== 1'b0 || n_out_valid !== 1'b0 || n_count !== 3'd0 || n_err_addr !== 32'h21) begin
            n_err++;
            $display("FAIL sh_0x21_pulse: got err=%b vld=%b cnt=%0d eaddr=%h, want 0 0 0 00000021",
                     n_store_err, n_out_valid, n_count, n_err_addr);
        end
        drive_n(32'h24, 32'hCAFE, 2'b01);
        @(posedge clk); #1;
        n_cmp++;
        if (n_store_err !== 1'b0 || n_out_valid !== 1'b1 || n_out_addr !== 32'h24 ||
            n_out_data !== 32'h0000CAFE || n_out_strb !== 4'b0011) begin
            n_err++;
            $display("FAIL sh_0x24_beat: got err=%b vld=%b addr=%h data=%h strb=%b, want 0 1 00000024 0000cafe 0011",
                     n_store_err, n_out_valid, n_out_addr, n_out_data, n_out_strb);
        end
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
        n_cmp++;
        if (n_out_valid !== 1'b0 || n_count !== 3'd0) begin
            n_err++;
            $display("FAIL sh_0x24_pop: got vld=%b cnt=%0d, want 0 0", n_out_valid, n_count);
        end
    endtask

    task automatic test_dword();
        drive_w(32'h08, 64'h0102030405060708, 2'b11);
        @(posedge clk); #1;
        n_cmp++;
        if (w_out_valid !== 1'b1 || w_out_addr !== 32'h08 ||
            w_out_data !== 64'h0102030405060708 || w_out_strb !== 8'hFF) begin
            n_err++;
            $display("FAIL sd64_beat: got vld=%b addr=%h data=%h strb=%h, want 1 00000008 0102030405060708 ff",
                     w_out_valid, w_out_addr, w_out_data, w_out_strb);
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        n_cmp++;
        if (w_out_valid !== 1'b0 || w_count !== 3'd0 || w_out_strb !== 8'h0) begin
            n_err++;
            $display("FAIL sd64_pop: got vld=%b cnt=%0d strb=%h, want 0 0 00", w_out_valid, w_count, w_out_strb);
        end
        drive_w(32'h0A, 64'hBEEF, 2'b01);
        @(posedge clk); #1;
        n_cmp++;
        if (w_out_valid !== 1'b1 || w_out_addr !== 32'h08 ||
            w_out_data !== 64'h00000000BEEF0000 || w_out_strb !== 8'h0C) begin
            n_err++;
            $display("FAIL sh64_beat: got vld=%b addr=%h data=%h strb=%h, want 1 00000008 00000000beef0000 0c",
                     w_out_valid, w_out_addr, w_out_data, w_out_strb);
        end
        w_out_ready = 1'b1;
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        drive_w(32'h0C, 64'h1, 2'b11);
        n_cmp++;
        if (w_store_err !== 1'b1 || w_err_addr !== 32'h0C || w_count !== 3'd0) begin
            n_err++;
            $display("FAIL sd64_misalign: got err=%b eaddr=%h cnt=%0d, want 1 0000000c 0",
                     w_store_err, w_err_addr, w_count);
        end
        drive_n(32'h08, 32'h05060708, 2'b11);
        n_cmp++;
        if (n_store_err !== 1'b1 || n_err_addr !== 32'h08 || n_count !== 3'd0) begin
            n_err++;
            $display("FAIL sd32_illegal: got err=%b eaddr=%h cnt=%0d, want 1 00000008 0",
                     n_store_err, n_err_addr, n_count);
        end
        drive_a(32'h10, 32'h05060708, 2'b11);
        n_cmp++;
        if (a_store_err !== 1'b1 || a_err_addr !== 32'h10 || a_count !== 3'd0) begin
            n_err++;
            $display("FAIL sd32_illegal_split: got err=%b eaddr=%h cnt=%0d, want 1 00000010 0",
                     a_store_err, a_err_addr, a_count);
        end
    endtask

    task automatic test_back_to_back();
        beat_t e;
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_a.push_back(mk(32'h100 + 32'(4*i), 64'(32'hA0B0C000 + 32'(i)), 8'b1111));
            drive_a(32'h100 + 32'(4*i), 32'hA0B0C000 + 32'(i), 2'b10);
        end
        n_cmp++;
        if (a_count !== 3'd4 || a_in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full: got cnt=%0d rdy=%b, want 4 0", a_count, a_in_ready);
        end
        a_in_valid = 1'b1; a_in_addr = 32'h110; a_in_data = 32'hA0B0C004; a_in_size = 2'b10;
        @(posedge clk); #1;
        n_cmp++;
        if (a_count !== 3'd4 || a_out_valid !== 1'b1 || a_out_addr !== 32'h100 || a_out_data !== 32'hA0B0C000) begin
            n_err++;
            $display("FAIL stall_hold: got cnt=%0d vld=%b addr=%h data=%h, want 4 1 00000100 a0b0c000",
                     a_count, a_out_valid, a_out_addr, a_out_data);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        e = exp_a.pop_front();
        n_cmp++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_addr !== e.addr || a_out_data !== e.data[31:0]) begin
            n_err++;
            $display("FAIL full_pop: got rdy=%b vld=%b addr=%h data=%h, want 0 1 %h %h",
                     a_in_ready, a_out_valid, a_out_addr, a_out_data, e.addr, e.data[31:0]);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (a_count !== 3'd3) begin
            n_err++;
            $display("FAIL full_pop_count: got %0d, want 3", a_count);
        end
        exp_a.push_back(mk(32'h110, 64'hA0B0C004, 8'b1111));
        @(negedge clk);
        e = exp_a.pop_front();
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_out_addr !== e.addr || a_out_data !== e.data[31:0] || a_out_strb !== e.strb[3:0]) begin
            n_err++;
            $display("FAIL push_pop_beat: got rdy=%b addr=%h data=%h strb=%b, want 1 %h %h %b",
                     a_in_ready, a_out_addr, a_out_data, a_out_strb, e.addr, e.data[31:0], e.strb[3:0]);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        n_cmp++;
        if (a_count !== 3'd3) begin
            n_err++;
            $display("FAIL push_pop_count: got %0d, want 3", a_count);
        end
        drain_a("fifo_order", 30);
    endtask

    task automatic test_reset_mid_split();
        a_out_ready = 1'b0;
        drive_a(32'h06, 32'h11223344, 2'b10);
        drive_a(32'h40, 32'h55, 2'b00);
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_addr !== 32'h04 || a_count !== 3'd2) begin
            n_err++;
            $display("FAIL mid_split_beat0: got vld=%b addr=%h cnt=%0d, want 1 00000004 2",
                     a_out_valid, a_out_addr, a_count);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_addr !== 32'h08 || a_out_strb !== 4'b0011) begin
            n_err++;
            $display("FAIL mid_split_beat1: got vld=%b addr=%h strb=%b, want 1 00000008 0011",
                     a_out_valid, a_out_addr, a_out_strb);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_count !== 3'd0 || a_out_strb !== 4'b0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_split_reset: got vld=%b cnt=%0d strb=%b rdy=%b, want 0 0 0000 1",
                     a_out_valid, a_count, a_out_strb, a_in_ready);
        end
        a_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_count !== 3'd0) begin
            n_err++;
            $display("FAIL mid_split_after: got vld=%b cnt=%0d, want 0 0", a_out_valid, a_count);
        end
    endtask

    task automatic test_random_batches();
        logic [31:0] addr, data;
        logic [1:0] sz;
        for (int b = 0; b < 6; b++) begin
            a_out_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                addr = 32'($urandom_range(0, 255));
                sz   = 2'($urandom_range(0, 2));
                data = $urandom;
                if (sz == 2'b00) data = data & 32'hFF;
                if (sz == 2'b01) data = data & 32'hFFFF;
                model_push_a(addr, data, sz);
                drive_a(addr, data, sz);
            end
            drain_a("random_batch", 40);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_in_addr = 0; a_in_data = 0; a_in_size = 0; a_out_ready = 0;
        n_in_valid = 0; n_in_addr = 0; n_in_data = 0; n_in_size = 0; n_out_ready = 0;
        w_in_valid = 0; w_in_addr = 0; w_in_data = 0; w_in_size = 0; w_out_ready = 0;
        test_reset();
        test_byte_store();
        test_split();
        test_misalign_err();
        test_dword();
        test_back_to_back();
        test_reset_mid_split();
        test_random_batches();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
